exmem_pipe_stage: RTL and testbench

// - Parametrised EX->MEM pipeline stage register. Successor to the fixed-field enable-gated latch.
// - Adds a valid/ready handshake, flush, a saturating stall counter and an optional skid buffer.
// - Sits between the execute stage and the memory stage.
// - Upstream presents the packed EX result bundle; downstream is the MEM stage.
// - hit is the global memory-hit enable: when hit=0 the whole stage is frozen.

---
 rtl/exmem_pipe_stage.sv | 172 +++++++++++++++++
 tb/tb_exmem_pipe_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/exmem_pipe_stage.sv
// exmem_pipe_stage: EX->MEM pipeline register with valid/ready handshake,
// flush, a saturating stall counter and an optional second (skid) entry.
// Optional feature macro: EXMEM_SKID_BUFFER_EN (skid entry; in_ready no
// longer depends combinationally on out_ready). Undefined builds base mode.
//
// Skid-mode states:
//   state | meaning
//   EMPTY | no bundle held, out_valid=0
//   FULL  | main register holds the bundle presented to MEM
//   SKID  | main and skid registers both hold bundles; input refused
module exmem_pipe_stage #(
    parameter int DATA_W  = 256,
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hit,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic               out_noop,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic [CNT_W-1:0] stall_cnt_q;

`ifdef EXMEM_SKID_BUFFER_EN

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  data_q;
    logic [PC_W-1:0]    pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic [DATA_W-1:0]  skid_data_q;
    logic [PC_W-1:0]    skid_pc_q;
    logic [INSTR_W-1:0] skid_instr_q;

    // Input is refused only while the skid entry is occupied.
    assign in_ready  = hit && !flush && (state_q != SKID);
    assign out_valid = (state_q != EMPTY);

    // Two-entry FIFO sequencing; flush drops both entries but keeps data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EMPTY;
            data_q       <= '0;
            pc_q         <= '0;
            instr_q      <= '0;
            skid_data_q  <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
        end else if (hit) begin
            unique case (state_q)
                EMPTY: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        pc_q    <= in_pc;
                        instr_q <= in_instr;
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (in_valid && !out_ready) begin
                        skid_data_q  <= in_data;
                        skid_pc_q    <= in_pc;
                        skid_instr_q <= in_instr;
                        state_q      <= SKID;
                    end else if (in_valid && out_ready) begin
                        data_q  <= in_data;
                        pc_q    <= in_pc;
                        instr_q <= in_instr;
                    end else if (out_ready) begin
                        state_q <= EMPTY;
                    end
                end
                SKID: begin
                    if (out_ready) begin
                        data_q  <= skid_data_q;
                        pc_q    <= skid_pc_q;
                        instr_q <= skid_instr_q;
                        state_q <= FULL;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

`else

    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               in_xfer;
    logic               out_xfer;

    // Single entry: a new bundle may replace the held one in the cycle MEM takes it.
    assign in_ready  = hit && !flush && (!valid_q || out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = valid_q && out_ready && hit;
    assign out_valid = valid_q;

    // Next-state selection: flush squashes, input loads, output drains.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_xfer) begin
            valid_d = 1'b1;
            data_d  = in_data;
            pc_d    = in_pc;
            instr_d = in_instr;
        end else if (out_xfer) begin
            valid_d = 1'b0;
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

`endif

    // Count stalled cycles, saturating; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (hit && out_valid && !out_ready && !flush &&
                     (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign out_data  = data_q;
    assign out_pc    = pc_q;
    assign out_instr = instr_q;
    assign out_noop  = !out_valid;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_exmem_pipe_stage.sv
// tb_exmem_pipe_stage: directed and randomized checks of exmem_pipe_stage
// against a queue-based FIFO model (capacity 1 in base mode, 2 with
// EXMEM_SKID_BUFFER_EN).
module tb_exmem_pipe_stage;

    localparam int DATA_W  = 64;
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef EXMEM_SKID_BUFFER_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [DATA_W-1:0]  d;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] ins;
    } bundle_t;

    logic               clk = 1'b0;
    logic               reset, hit, flush, in_valid, out_ready;
    logic               in_ready, out_valid, out_noop;
    logic [DATA_W-1:0]  in_data, out_data;
    logic [PC_W-1:0]    in_pc, out_pc;
    logic [INSTR_W-1:0] in_instr, out_instr;
    logic [CNT_W-1:0]   stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    bundle_t q[$];
    bundle_t last_head;
    int      m_cnt;

    exmem_pipe_stage #(
        .DATA_W(DATA_W), .PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .hit(hit), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_pc(out_pc), .out_instr(out_instr),
        .out_noop(out_noop), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bundle_t rand_bundle();
        bundle_t b;
        b.d   = {$urandom, $urandom};
        b.pc  = $urandom;
        b.ins = $urandom;
        return b;
    endfunction

    function automatic logic model_ready();
        if (!hit || flush) return 1'b0;
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || out_ready;
    endfunction

    task automatic drive(input logic r, input logic h, input logic f,
                         input logic iv, input logic ordy, input bundle_t b);
        reset = r; hit = h; flush = f; in_valid = iv; out_ready = ordy;
        in_data = b.d; in_pc = b.pc; in_instr = b.ins;
    endtask

    // One clock: check in_ready, advance model at the edge, check outputs.
    task automatic cyc();
        logic    acc;
        bundle_t inb;
        #1;
        if (!reset) check("in_ready", 64'(in_ready), 64'(model_ready()));
        acc = in_valid && model_ready();
        inb.d = in_data; inb.pc = in_pc; inb.ins = in_instr;
        @(posedge clk);
        if (reset) begin
            q.delete();
            last_head = '0;
            m_cnt = 0;
        end else if (flush) begin
            q.delete();
        end else if (hit) begin
            if (q.size() > 0 && !out_ready && m_cnt < CNT_MAX) m_cnt++;
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back(inb);
        end
        if (q.size() > 0) last_head = q[0];
        #1;
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check("out_noop",  64'(out_noop),  64'(q.size() == 0));
        check("out_data",  out_data,       last_head.d);
        check("out_pc",    64'(out_pc),    64'(last_head.pc));
        check("out_instr", 64'(out_instr), 64'(last_head.ins));
        check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    endtask

    initial begin
        bundle_t b, a5;
        bundle_t stream [8];
        m_cnt = 0;
        last_head = '0;

        // Reset for 2 cycles.
        drive(1, 1, 0, 0, 0, '0);
        cyc(); cyc();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_noop",  64'(out_noop),  64'd1);
        check("rst_stall",     64'(stall_cnt), 64'd0);
        check("rst_out_data",  out_data,       64'd0);

        // Stream 8 bundles back to back.
        for (int i = 0; i < 8; i++) begin
            stream[i] = rand_bundle();
            drive(0, 1, 0, 1, 1, stream[i]);
            cyc();
            check("stream_ready", 64'(in_ready), 64'd1);
            check("stream_data",  out_data, stream[i].d);
            check("stream_pc",    64'(out_pc), 64'(stream[i].pc));
        end
        drive(0, 1, 0, 0, 1, '0);
        cyc();

        // Load 0xA5 and stall for 5 cycles.
        drive(1, 1, 0, 0, 0, '0);
        cyc();
        a5 = rand_bundle();
        a5.d = 64'hA5;
        drive(0, 1, 0, 1, 1, a5);
        cyc();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 1, 0, rand_bundle());
            cyc();
        end
        check("stall_data", out_data, 64'hA5);
        check("stall_cnt5", 64'(stall_cnt), 64'd5);
        check("stall_ready", 64'(in_ready), 64'd0);

        // Frozen by hit=0.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 1, rand_bundle());
            cyc();
        end
        check("frozen_cnt",  64'(stall_cnt), 64'd5);
        check("frozen_data", out_data, 64'hA5);
        check("frozen_valid", 64'(out_valid), 64'd1);

        // Flush with held bundle(s) and a valid input.
        drive(0, 1, 1, 1, 0, rand_bundle());
        cyc();
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_data",  out_data, 64'hA5);
        drive(0, 1, 0, 0, 0, '0);
        cyc();
        check("flush_stays_empty", 64'(out_valid), 64'd0);

        // Reset while flush and in_valid are high, then normal accept.
        drive(1, 1, 1, 1, 1, rand_bundle());
        cyc(); cyc();
        check("rst2_valid", 64'(out_valid), 64'd0);
        check("rst2_data",  out_data, 64'd0);
        b = rand_bundle();
        drive(0, 1, 0, 1, 1, b);
        cyc();
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_data",  out_data, b.d);

        // Saturation: 20 stall cycles on a 4-bit counter.
        drive(0, 1, 0, 0, 0, '0);
        for (int i = 0; i < 20; i++) cyc();
        check("sat_cnt", 64'(stall_cnt), 64'd15);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) != 0, rand_bundle());
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
